// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// Optional feature macro MULDIV_MTHILO_EN adds mthi/mtlo direct writes of rsData into HI/LO.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rsData,
   input  logic [WIDTH-1:0] rtData,
   input  logic             flush,
`ifdef MULDIV_MTHILO_EN
   input  logic             mthi,
   input  logic             mtlo,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Handshake: start+funct is taken only while busy==0 and flush==0. busy then stays high
   // until the result is written. done pulses for one cycle (with busy==0) once hi/lo hold it,
   // and a new start may be presented in that same cycle.
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic             accept;
   logic             step;
   logic             write_res;
   logic             mt_hi_wr;
   logic             mt_lo_wr;
   logic             funct_ok;

   logic [CW-1:0]    count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] rs_raw;
   logic             op_div;
   logic             neg_q;
   logic             neg_r;
   logic             div_zero;

   assign funct_ok = (funct == F_MULT) || (funct == F_MULTU) ||
                     (funct == F_DIV)  || (funct == F_DIVU);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      accept    = 1'b0;
      step      = 1'b0;
      write_res = 1'b0;
      mt_hi_wr  = 1'b0;
      mt_lo_wr  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!flush && start && funct_ok) begin
               accept   = 1'b1;
               state_nx = S_RUN;
            end
`ifdef MULDIV_MTHILO_EN
            // A same-cycle accepted start takes priority over the direct HI/LO writes.
            mt_hi_wr = !flush && !accept && mthi;
            mt_lo_wr = !flush && !accept && mtlo;
`endif
         end
         S_RUN: begin
            if (flush) begin
               state_nx = S_IDLE;
            end else begin
               step = 1'b1;
               if (count == LAST) begin
                  state_nx = S_FIX;
               end
            end
         end
         S_FIX: begin
            state_nx = S_IDLE;
            if (!flush) begin
               write_res = 1'b1;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Operand conditioning at accept: signed ops run on magnitudes, signs are reapplied in FIX.
   logic             is_signed;
   logic             is_div;
   logic             rs_neg;
   logic             rt_neg;
   logic [WIDTH-1:0] rs_abs;
   logic [WIDTH-1:0] rt_abs;

   assign is_signed = ~funct[0];
   assign is_div    = funct[1];
   assign rs_neg    = is_signed & rsData[WIDTH-1];
   assign rt_neg    = is_signed & rtData[WIDTH-1];
   assign rs_abs    = rs_neg ? -rsData : rsData;
   assign rt_abs    = rt_neg ? -rtData : rtData;

   // Multiply iteration: add multiplicand into the upper half when the LSB is set, then shift right.
   logic [WIDTH:0]     add_sum;
   logic [2*WIDTH-1:0] mul_acc_nx;

   assign add_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
   assign mul_acc_nx = {add_sum, acc[WIDTH-1:1]};

   // Divide iteration: shift in the next dividend bit, subtract the divisor if it fits.
   logic [WIDTH:0]     shifted;
   logic               fits;
   logic [WIDTH-1:0]   rem_nx;
   logic [2*WIDTH-1:0] div_acc_nx;

   assign shifted    = acc[2*WIDTH-1:WIDTH-1];
   assign fits       = (shifted >= {1'b0, opb});
   assign rem_nx     = fits ? (shifted[WIDTH-1:0] - opb) : shifted[WIDTH-1:0];
   assign div_acc_nx = {rem_nx, acc[WIDTH-2:0], fits};

   // Sign correction and special cases, consumed on the FIX edge.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      prod   = neg_q ? -acc : acc;
      quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (op_div) begin
         if (div_zero) begin
            res_hi = rs_raw;
            res_lo = '1;
         end else begin
            res_hi = rem;
            res_lo = quo;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         count    <= '0;
         acc      <= '0;
         opb      <= '0;
         rs_raw   <= '0;
         op_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         busy <= (state_nx != S_IDLE);
         done <= write_res;
         if (accept) begin
            count    <= '0;
            acc      <= {{WIDTH{1'b0}}, rs_abs};
            opb      <= rt_abs;
            rs_raw   <= rsData;
            op_div   <= is_div;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg & is_div;
            div_zero <= is_div && (rtData == '0);
         end
         if (step) begin
            count <= count + CW'(1);
            acc   <= op_div ? div_acc_nx : mul_acc_nx;
         end
         if (write_res) begin
            hi <= res_hi;
            lo <= res_lo;
         end
         if (mt_hi_wr) begin
            hi <= rsData;
         end
         if (mt_lo_wr) begin
            lo <= rsData;
         end
      end
   end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle iterative multiply/divide unit for the execute stage; owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU from decode with rs/rt operands.
- Drives hi/lo directly into the ALU, which returns them for MFHI/MFLO.
- Asserts busy so the hazard logic stalls any MFHI/MFLO or new mult/div until the result is written.

Parameters:
- WIDTH, 32, operand width; hi/lo are WIDTH bits each; iteration count = WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- start  input  1  request; sampled only when idle
- funct  input  6  011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU
- rsData  input  WIDTH  multiplicand / dividend
- rtData  input  WIDTH  multiplier / divisor
- flush  input  1  pipeline flush; cancels in-flight op
- busy  output  1  op in flight
- done  output  1  one-cycle pulse when hi/lo are updated
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at an edge): state IDLE, busy=0, done=0, hi=0, lo=0, count=0. Reset overrides everything, including mid-operation.
- States: IDLE -> RUN -> FIX -> IDLE. busy=1 in RUN and FIX; busy and done are registered.
- IDLE:
  - Accept when start=1 and funct is one of the four codes.
  - On the accept edge: latch operands and op. For signed ops, latch absolute values and record result signs.
  - Go to RUN with count=0.
  - start with any other funct is ignored.
- RUN, one iteration per cycle, exactly WIDTH cycles (count 0..WIDTH-1):
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits.
  - Go to FIX on the edge where count==WIDTH-1.
- FIX, one cycle:
  - Apply sign correction.
  - Write hi/lo; done=1 in the following cycle; return to IDLE.
- Latency: accept edge E0, hi/lo written at E(WIDTH+1), i.e. E33 for WIDTH=32. busy is high for 33 cycles; done is high for the cycle after E33, coincident with busy=0.
- Back-to-back: start while done=1 is accepted (state is IDLE).
- MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product.
- DIV/DIVU:
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (any divide): hi = rsData as latched, lo = all ones.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- start while busy: ignored; the in-flight op is unaffected.
- flush:
  - In RUN or FIX: return to IDLE next edge; hi/lo unchanged; no done.
  - In IDLE with start: flush wins, no accept.
- hi/lo change only at the FIX edge, at reset, or via the optional feature.

Optional Feature:
- Macro MULDIV_MTHILO_EN defined:
  - Adds input ports mthi and mtlo (1 bit each).
  - In IDLE with start not accepted, mthi=1 writes hi = rsData at the edge; mtlo=1 writes lo = rsData. Both may be asserted together.
  - Ignored while busy, or when start is accepted the same cycle (start wins). flush blocks the write.
- Macro undefined: ports absent; hi/lo writable only by mult/div results.

Test Plan:
- Reset then MULT rs=7, rt=0xFFFFFFFD -> busy for 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV rs=0xFFFFFFF9 (-7), rt=2 issued in the done cycle -> accepted immediately; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> hi=100, lo=0xFFFFFFFF. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=7 accepted; start MULT asserted at busy cycle 5 -> ignored; result hi=2, lo=14; exactly one done.
- MULT in flight; flush at busy cycle 10 -> busy=0 next cycle; hi/lo keep prior values; no done. reset=0 at busy cycle 20 of a new op -> hi=lo=0, busy=0.
- With MULDIV_MTHILO_EN: IDLE, mthi=1, rs=0x12345678 -> hi=0x12345678. mtlo while busy -> lo unchanged. mtlo together with accepted start -> start proceeds, mtlo dropped.
